// File: rtl/imm_target_pipe.sv
// Two-stage RV32I immediate decoder and PC-relative target generator with valid/ready flow control.
// Optional macro IMM_TARGET_MISALIGN_EN adds a registered target_misalign output for B/J targets.

package imm_target_pkg;
  localparam logic [2:0] F_R   = 3'd0;
  localparam logic [2:0] F_I   = 3'd1;
  localparam logic [2:0] F_S   = 3'd2;
  localparam logic [2:0] F_B   = 3'd3;
  localparam logic [2:0] F_U   = 3'd4;
  localparam logic [2:0] F_J   = 3'd5;
  localparam logic [2:0] F_ILL = 3'd7;
endpackage

module imm_target_dec #(
  parameter int XLEN = 32
) (
  input  logic [31:0]     inst,
  output logic [XLEN-1:0] imm,
  output logic [2:0]      fmt,
  output logic            illegal
);
  import imm_target_pkg::*;

  always_comb begin
    fmt = F_ILL;
    if (inst[1:0] == 2'b11) begin
      unique case (inst[6:2])
        5'b01101, 5'b00101:                   fmt = F_U;
        5'b11011:                             fmt = F_J;
        5'b11001, 5'b00000, 5'b00100, 5'b11100: fmt = F_I;
        5'b01000:                             fmt = F_S;
        5'b11000:                             fmt = F_B;
        5'b01100:                             fmt = F_R;
        default:                              fmt = F_ILL;
      endcase
    end
  end

  // Signed size casts do the sign extension, so XLEN=64 needs no extra fields.
  always_comb begin
    imm = '0;
    unique case (fmt)
      F_I:     imm = XLEN'($signed(inst[31:20]));
      F_S:     imm = XLEN'($signed({inst[31:25], inst[11:7]}));
      F_B:     imm = XLEN'($signed({inst[31], inst[7], inst[30:25], inst[11:8], 1'b0}));
      F_U:     imm = XLEN'($signed({inst[31:12], 12'b0}));
      F_J:     imm = XLEN'($signed({inst[31], inst[19:12], inst[20], inst[30:21], 1'b0}));
      default: imm = '0;
    endcase
  end

  assign illegal = (fmt == F_ILL);
endmodule

module imm_target_pipe #(
  parameter int XLEN = 32
) (
  input  logic            clk,
  input  logic            rst_n,
  input  logic            flush,
  input  logic            in_valid,
  output logic            in_ready,
  input  logic [31:0]     inst,
  input  logic [XLEN-1:0] pc,
  output logic            out_valid,
  input  logic            out_ready,
  output logic [XLEN-1:0] imm,
  output logic [XLEN-1:0] target,
  output logic [2:0]      fmt,
  output logic            illegal
`ifdef IMM_TARGET_MISALIGN_EN
  ,
  output logic            target_misalign
`endif
);
  import imm_target_pkg::*;

  typedef struct packed {
    logic [XLEN-1:0] imm;
    logic [2:0]      fmt;
    logic            illegal;
  } dec_t;

  dec_t            dec, s1, s2;
  logic [XLEN-1:0] s1_pc, s1_sum, s2_target;
  logic [2:1]      vld_pipe;
  logic            s1_adv, s2_adv, accept;

  imm_target_dec #(.XLEN(XLEN)) u_dec (
    .inst    (inst),
    .imm     (dec.imm),
    .fmt     (dec.fmt),
    .illegal (dec.illegal)
  );

  assign s2_adv   = !vld_pipe[2] || out_ready;
  assign s1_adv   = !vld_pipe[1] || s2_adv;
  assign in_ready = rst_n && s1_adv && !flush;
  assign accept   = in_valid && in_ready;
  assign s1_sum   = s1_pc + s1.imm;

`ifdef IMM_TARGET_MISALIGN_EN
  logic s1_mis, s2_mis;
  assign s1_mis = ((s1.fmt == F_B) || (s1.fmt == F_J)) && (s1_sum[1:0] != 2'b00);
`endif

  // Flush only kills the valid bits; data registers are left as-is.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      vld_pipe  <= '0;
      s1        <= '0;
      s1_pc     <= '0;
      s2        <= '0;
      s2_target <= '0;
`ifdef IMM_TARGET_MISALIGN_EN
      s2_mis    <= 1'b0;
`endif
    end else if (flush) begin
      vld_pipe <= '0;
    end else begin
      if (s2_adv) begin
        vld_pipe[2] <= vld_pipe[1];
        if (vld_pipe[1]) begin
          s2        <= s1;
          s2_target <= s1_sum;
`ifdef IMM_TARGET_MISALIGN_EN
          s2_mis    <= s1_mis;
`endif
        end
      end
      if (s1_adv) begin
        vld_pipe[1] <= accept;
        if (accept) begin
          s1    <= dec;
          s1_pc <= pc;
        end
      end
    end
  end

  assign out_valid = vld_pipe[2];
  assign imm       = s2.imm;
  assign fmt       = s2.fmt;
  assign illegal   = s2.illegal;
  assign target    = s2_target;
`ifdef IMM_TARGET_MISALIGN_EN
  assign target_misalign = s2_mis;
`endif
endmodule

// File: tb/tb_imm_target_pipe.sv
// Scoreboard bench for imm_target_pipe: directed cases plus randomized traffic against an arithmetic model.
module tb_imm_target_pipe;
  localparam int XLEN = 32;

  logic            clk = 1'b0;
  logic            rst_n = 1'b0;
  logic            flush = 1'b0;
  logic            in_valid = 1'b0;
  logic            in_ready;
  logic [31:0]     inst = '0;
  logic [XLEN-1:0] pc = '0;
  logic            out_valid;
  logic            out_ready = 1'b1;
  logic [XLEN-1:0] imm, target;
  logic [2:0]      fmt;
  logic            illegal;
`ifdef IMM_TARGET_MISALIGN_EN
  logic            target_misalign;
`endif

  imm_target_pipe #(.XLEN(XLEN)) dut (
    .clk       (clk),
    .rst_n     (rst_n),
    .flush     (flush),
    .in_valid  (in_valid),
    .in_ready  (in_ready),
    .inst      (inst),
    .pc        (pc),
    .out_valid (out_valid),
    .out_ready (out_ready),
    .imm       (imm),
    .target    (target),
    .fmt       (fmt),
    .illegal   (illegal)
`ifdef IMM_TARGET_MISALIGN_EN
    ,
    .target_misalign (target_misalign)
`endif
  );

  always #5 clk = ~clk;

  typedef struct {
    logic [XLEN-1:0] imm;
    logic [XLEN-1:0] tgt;
    logic [2:0]      fmt;
    logic            ill;
    logic            mis;
  } exp_t;

  exp_t exp_q[$];
  int   n_cmp = 0;
  int   n_bad = 0;

  task automatic chk(input string nm, input logic [63:0] got, input logic [63:0] req);
    n_cmp++;
    if (got !== req) begin
      n_bad++;
      $display("FAIL %s: got %0h required %0h (t=%0t)", nm, got, req, $time);
    end
  endtask

  function automatic longint sx(input longint v, input int bits);
    longint r = v;
    if (r >= (longint'(1) << (bits - 1))) r = r - (longint'(1) << bits);
    return r;
  endfunction

  // Reference: classify by opcode, build the immediate as a signed integer, add with 64-bit arithmetic.
  function automatic exp_t model(input logic [31:0] i, input logic [XLEN-1:0] p);
    exp_t   e;
    int     f = 7;
    longint v = 0;
    logic [63:0] sum;
    if (i[1:0] == 2'b11) begin
      case (i[6:2])
        5'b01101, 5'b00101:                     f = 4;
        5'b11011:                               f = 5;
        5'b11001, 5'b00000, 5'b00100, 5'b11100: f = 1;
        5'b01000:                               f = 2;
        5'b11000:                               f = 3;
        5'b01100:                               f = 0;
        default:                                f = 7;
      endcase
    end
    case (f)
      1: v = sx(longint'(i[31:20]), 12);
      2: v = sx(longint'({i[31:25], i[11:7]}), 12);
      3: v = sx(longint'({i[31], i[7], i[30:25], i[11:8]}), 12) * 2;
      4: v = sx(longint'(i[31:12]), 20) * 4096;
      5: v = sx(longint'({i[31], i[19:12], i[20], i[30:21]}), 20) * 2;
      default: v = 0;
    endcase
    sum   = 64'(p) + 64'(v);
    e.imm = XLEN'(v);
    e.tgt = sum[XLEN-1:0];
    e.fmt = 3'(f);
    e.ill = (f == 7);
    e.mis = ((f == 3) || (f == 5)) && (sum[1:0] != 2'b00);
    return e;
  endfunction

  // Snapshot of DUT state taken inside each driven cycle, before its rising edge.
  logic            s_vld, s_rdy, s_ill;
  logic [XLEN-1:0] s_imm, s_tgt;
  logic [2:0]      s_fmt;
`ifdef IMM_TARGET_MISALIGN_EN
  logic            s_mis;
`endif

  task automatic cyc(input logic v, input logic [31:0] i, input logic [XLEN-1:0] p,
                     input logic ordy, input logic fl, output logic acc);
    logic fl_s;
    @(negedge clk); #1;
    in_valid = v; inst = i; pc = p; out_ready = ordy; flush = fl;
    #1;
    acc  = v && in_ready && rst_n;
    fl_s = fl;
    #1;
    s_vld = out_valid; s_rdy = in_ready; s_imm = imm; s_tgt = target;
    s_fmt = fmt; s_ill = illegal;
`ifdef IMM_TARGET_MISALIGN_EN
    s_mis = target_misalign;
`endif
    @(posedge clk);
    if (!rst_n || fl_s) exp_q.delete();
    else if (acc) exp_q.push_back(model(i, p));
    #1;
    in_valid = 1'b0; flush = 1'b0;
  endtask

  task automatic idle(input int n);
    logic a;
    for (int k = 0; k < n; k++) cyc(1'b0, 32'h0, '0, 1'b1, 1'b0, a);
  endtask

  localparam logic [4:0] OPS [0:9] = '{5'b01101, 5'b00101, 5'b11011, 5'b11001, 5'b00000,
                                       5'b00100, 5'b11100, 5'b01000, 5'b11000, 5'b01100};

  function automatic logic [31:0] rnd_inst();
    logic [31:0] r = $urandom;
    int k = $urandom_range(0, 11);
    if (k < 10) begin r[6:2] = OPS[k]; r[1:0] = 2'b11; end
    else if (k == 10) r[1:0] = 2'b11;
    return r;
  endfunction

  // Monitor: pops the scoreboard on each output transfer and checks stability while stalled.
  logic            held = 1'b0;
  logic [XLEN-1:0] h_imm, h_tgt;
  logic [2:0]      h_fmt;
  logic            h_ill;
  always begin
    exp_t e;
    @(negedge clk); #3;
    if (rst_n && out_valid) begin
      if (held) begin
        chk("hold_imm", 64'(imm), 64'(h_imm));
        chk("hold_target", 64'(target), 64'(h_tgt));
        chk("hold_fmt", 64'(fmt), 64'(h_fmt));
        chk("hold_illegal", 64'(illegal), 64'(h_ill));
      end
      if (out_ready) begin
        if (exp_q.size() == 0) begin
          n_cmp++; n_bad++;
          $display("FAIL unexpected_out: got out_valid=1 required no pending result (t=%0t)", $time);
        end else begin
          e = exp_q.pop_front();
          chk("sb_imm", 64'(imm), 64'(e.imm));
          chk("sb_target", 64'(target), 64'(e.tgt));
          chk("sb_fmt", 64'(fmt), 64'(e.fmt));
          chk("sb_illegal", 64'(illegal), 64'(e.ill));
`ifdef IMM_TARGET_MISALIGN_EN
          chk("sb_misalign", 64'(target_misalign), 64'(e.mis));
`endif
        end
        held = 1'b0;
      end else begin
        held = 1'b1; h_imm = imm; h_tgt = target; h_fmt = fmt; h_ill = illegal;
      end
    end else begin
      held = 1'b0;
    end
  end

  initial begin
    logic        acc;
    logic [31:0] bp_i [0:2];
    int          k, na;

    // Reset
    cyc(1'b0, 32'h0, '0, 1'b1, 1'b0, acc);
    cyc(1'b1, 32'hFFF00093, '0, 1'b1, 1'b0, acc);
    chk("rst_in_ready", 64'(s_rdy), 64'd0);
    chk("rst_accept", 64'(acc), 64'd0);
    chk("rst_out_valid", 64'(s_vld), 64'd0);
    chk("rst_imm", 64'(s_imm), 64'd0);
    chk("rst_target", 64'(s_tgt), 64'd0);
    chk("rst_fmt", 64'(s_fmt), 64'd0);
    chk("rst_illegal", 64'(s_ill), 64'd0);
    rst_n = 1'b1;

    // addi x1,x0,-1 : exactly two cycles of latency
    cyc(1'b1, 32'hFFF00093, 32'h0, 1'b1, 1'b0, acc);
    chk("addi_accept", 64'(acc), 64'd1);
    idle(1);
    chk("addi_lat1_valid", 64'(s_vld), 64'd0);
    idle(1);
    chk("addi_lat2_valid", 64'(s_vld), 64'd1);
    chk("addi_imm", 64'(s_imm), 64'hFFFFFFFF);
    chk("addi_fmt", 64'(s_fmt), 64'd1);
    chk("addi_target", 64'(s_tgt), 64'hFFFFFFFF);
    chk("addi_illegal", 64'(s_ill), 64'd0);

    // beq x0,x0,-4
    cyc(1'b1, 32'hFE000EE3, 32'h100, 1'b1, 1'b0, acc);
    idle(2);
    chk("beq_valid", 64'(s_vld), 64'd1);
    chk("beq_imm", 64'(s_imm), 64'hFFFFFFFC);
    chk("beq_fmt", 64'(s_fmt), 64'd3);
    chk("beq_target", 64'(s_tgt), 64'hFC);

    // lui then jal back to back
    cyc(1'b1, 32'h123452B7, 32'h0, 1'b1, 1'b0, acc);
    cyc(1'b1, 32'h0080006F, 32'h200, 1'b1, 1'b0, acc);
    chk("jal_accept", 64'(acc), 64'd1);
    idle(1);
    chk("lui_valid", 64'(s_vld), 64'd1);
    chk("lui_imm", 64'(s_imm), 64'h12345000);
    chk("lui_fmt", 64'(s_fmt), 64'd4);
    idle(1);
    chk("jal_valid", 64'(s_vld), 64'd1);
    chk("jal_imm", 64'(s_imm), 64'h8);
    chk("jal_fmt", 64'(s_fmt), 64'd5);
    chk("jal_target", 64'(s_tgt), 64'h208);
    idle(2);

    // Backpressure: 5 stalled cycles while offering 3 instructions
    for (int j = 0; j < 3; j++) bp_i[j] = rnd_inst();
    k = 0; na = 0;
    for (int c = 0; c < 5; c++) begin
      cyc(k < 3, bp_i[k % 3], XLEN'(32'h1000 + 4 * k), 1'b0, 1'b0, acc);
      if (acc) begin k++; na++; end
    end
    chk("bp_accepts", 64'(na), 64'd2);
    chk("bp_in_ready_low", 64'(s_rdy), 64'd0);
    for (int c = 0; c < 10 && k < 3; c++) begin
      cyc(1'b1, bp_i[k], XLEN'(32'h1000 + 4 * k), 1'b1, 1'b0, acc);
      if (acc) k++;
    end
    chk("bp_all_accepted", 64'(k), 64'd3);
    idle(4);
    chk("bp_drained", 64'(exp_q.size()), 64'd0);

    // Illegal opcode killed by flush one cycle later
    cyc(1'b1, 32'h0000007F, 32'h300, 1'b1, 1'b0, acc);
    cyc(1'b1, 32'hFFF00093, 32'h304, 1'b1, 1'b1, acc);
    chk("flush_drops_input", 64'(acc), 64'd0);
    chk("flush_in_ready", 64'(s_rdy), 64'd0);
    for (int c = 0; c < 3; c++) begin
      idle(1);
      chk("flush_no_valid", 64'(s_vld), 64'd0);
    end

    // Same illegal opcode without flush
    cyc(1'b1, 32'h0000007F, 32'h300, 1'b1, 1'b0, acc);
    idle(2);
    chk("ill_valid", 64'(s_vld), 64'd1);
    chk("ill_fmt", 64'(s_fmt), 64'd7);
    chk("ill_illegal", 64'(s_ill), 64'd1);
    chk("ill_imm", 64'(s_imm), 64'd0);
    idle(1);

`ifdef IMM_TARGET_MISALIGN_EN
    cyc(1'b1, 32'h0020006F, 32'h200, 1'b1, 1'b0, acc);
    idle(2);
    chk("mis_target", 64'(s_tgt), 64'h202);
    chk("mis_flag_set", 64'(s_mis), 64'd1);
    cyc(1'b1, 32'h0080006F, 32'h200, 1'b1, 1'b0, acc);
    idle(2);
    chk("mis_flag_clear", 64'(s_mis), 64'd0);
`endif

    // Randomized traffic with stalls and occasional flushes
    for (int c = 0; c < 600; c++) begin
      cyc($urandom_range(0, 3) != 0, rnd_inst(), XLEN'($urandom),
          $urandom_range(0, 3) != 0, $urandom_range(0, 39) == 0, acc);
    end

    for (int c = 0; c < 50 && exp_q.size() != 0; c++) idle(1);
    chk("final_drain", 64'(exp_q.size()), 64'd0);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end
endmodule
